countdown_tick_ctrl: RTL

Control and tick-source end of the digit-timer borrow chain. The block drives the reconfigure strobe and the one-cycle borrow-down tick into the least-significant digit timer. It monitors the "no borrow" (done) flag that returns from that digit. It runs the start/pause/expire sequencing for the game's countdown display, and signals the game FSM with a one-cycle timeout pulse.

---
 rtl/countdown_tick_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/countdown_tick_ctrl.sv
// Countdown sequencer at the root of the digit-timer borrow chain: reloads the
// digits, issues borrow-down ticks, and reports start/pause/expire status.
module countdown_tick_ctrl #(
  parameter int unsigned TICK_DIV    = 50000000,
  parameter int unsigned CNT_W       = 26,
  parameter int unsigned LOAD_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic start,
  input  logic pause,
  input  logic digits_done,
  output logic reconfig_out,
  output logic tick_out,
  output logic running,
  output logic paused,
  output logic expired,
  output logic timeout_pulse
);

  localparam int unsigned LC_W = (LOAD_CYCLES > 2) ? $clog2(LOAD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [LC_W-1:0]  LOAD_LAST  = LC_W'(LOAD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_PAUSED,
    S_EXPIRED
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  presc_q, presc_d;
  logic [LC_W-1:0]   load_cnt_q, load_cnt_d;
  logic              ign_done_q, ign_done_d;
  logic              reconfig_q, reconfig_d;
  logic              tick_q, tick_d;
  logic              running_q, running_d;
  logic              paused_q, paused_d;
  logic              expired_q, expired_d;
  logic              timeout_q, timeout_d;

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    load_cnt_d = load_cnt_q;
    ign_done_d = 1'b0;
    reconfig_d = 1'b0;
    tick_d     = 1'b0;
    timeout_d  = 1'b0;

    if (load) begin
      state_d    = S_LOAD;
      load_cnt_d = '0;
      presc_d    = '0;
      reconfig_d = 1'b1;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (load_cnt_q == LOAD_LAST) begin
            state_d = S_IDLE;
            // the digit's done flag is registered, so it is stale for one more cycle
            ign_done_d = 1'b1;
          end else begin
            load_cnt_d = load_cnt_q + 1'b1;
            reconfig_d = 1'b1;
          end
        end
        S_IDLE: begin
          if (start) begin
            if (digits_done && !ign_done_q) begin
              state_d   = S_EXPIRED;
              timeout_d = 1'b1;
            end else begin
              state_d = S_RUN;
              presc_d = '0;
            end
          end
        end
        S_RUN: begin
          if (digits_done) begin
            state_d   = S_EXPIRED;
            timeout_d = 1'b1;
          end else if (pause) begin
            state_d = S_PAUSED;
          end else if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            tick_d  = 1'b1;
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        S_PAUSED: begin
          if (digits_done) begin
            state_d   = S_EXPIRED;
            timeout_d = 1'b1;
          end else if (!pause) begin
            state_d = S_RUN;
          end
        end
        S_EXPIRED: begin
          state_d = S_EXPIRED;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    running_d = (state_d == S_RUN);
    paused_d  = (state_d == S_PAUSED);
    expired_d = (state_d == S_EXPIRED);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      presc_q    <= '0;
      load_cnt_q <= '0;
      ign_done_q <= 1'b0;
      reconfig_q <= 1'b0;
      tick_q     <= 1'b0;
      running_q  <= 1'b0;
      paused_q   <= 1'b0;
      expired_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      load_cnt_q <= load_cnt_d;
      ign_done_q <= ign_done_d;
      reconfig_q <= reconfig_d;
      tick_q     <= tick_d;
      running_q  <= running_d;
      paused_q   <= paused_d;
      expired_q  <= expired_d;
      timeout_q  <= timeout_d;
    end
  end

  assign reconfig_out  = reconfig_q;
  assign tick_out      = tick_q;
  assign running       = running_q;
  assign paused        = paused_q;
  assign expired       = expired_q;
  assign timeout_pulse = timeout_q;

endmodule
